// File: rtl/enc4to2_rx.sv
// enc4to2_rx: one-hot to binary encoder with a 4-entry show-ahead FIFO.
// Flags and counts words that are not exactly one-hot.
module enc4to2_rx #(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_code,
   output logic             out_err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [2:0]       level
);

   logic [2:0]       mem_q [4];
   logic [2:0]       mem_d [4];
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [2:0]       level_q, level_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [1:0]       enc_code;
   logic             enc_err;
   logic             push, pop;

   // Encode: highest set bit wins; anything not exactly one-hot is an error.
   always_comb begin
      enc_code = 2'b00;
      if (in_y[3])      enc_code = 2'd3;
      else if (in_y[2]) enc_code = 2'd2;
      else if (in_y[1]) enc_code = 2'd1;
      unique case (in_y)
         4'b0001, 4'b0010,
         4'b0100, 4'b1000: enc_err = 1'b0;
         default:          enc_err = 1'b1;
      endcase
   end

   // Handshakes; reset holds intake off while asserted.
   assign in_ready  = rst_n & ~en_n & (level_q != 3'd4);
   assign out_valid = (level_q != 3'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Next-state for storage, pointers, occupancy and error counter.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q + 2'(push);
      rd_ptr_d  = rd_ptr_q + 2'(pop);
      level_d   = level_q + 3'(push) - 3'(pop);
      err_cnt_d = err_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = {enc_err, enc_code};
         if (enc_err && (err_cnt_q != {ERR_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // State registers; reset discards all entries immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q     <= '{default: 3'b000};
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         level_q   <= 3'd0;
         err_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_code = mem_q[rd_ptr_q][1:0];
   assign out_err  = mem_q[rd_ptr_q][2];
   assign err_cnt  = err_cnt_q;
   assign level    = level_q;

endmodule

// File: tb/tb_enc4to2_rx.sv
// tb_enc4to2_rx: directed + random checks against a queue-based model.
// Two instances cover the default and a 2-bit saturating counter.
module tb_enc4to2_rx;

   logic       clk = 1'b0;
   logic       rst_n, en_n, in_valid, out_ready;
   logic [3:0] in_y;
   logic       in_ready, out_valid, out_err;
   logic [1:0] out_code;
   logic [7:0] err_cnt;
   logic [2:0] level;
   logic       in_ready2, out_valid2, out_err2;
   logic [1:0] out_code2;
   logic [1:0] err_cnt2;
   logic [2:0] level2;

   int checks = 0;
   int errors = 0;

   logic [2:0] mq[$];
   int         cnt8, cnt2;

   always #5 clk = ~clk;

   enc4to2_rx dut (
      .clk(clk), .rst_n(rst_n), .en_n(en_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_code(out_code), .out_err(out_err),
      .err_cnt(err_cnt), .level(level)
   );

   enc4to2_rx #(.ERR_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en_n(en_n),
      .in_valid(in_valid), .in_ready(in_ready2), .in_y(in_y),
      .out_valid(out_valid2), .out_ready(out_ready),
      .out_code(out_code2), .out_err(out_err2),
      .err_cnt(err_cnt2), .level(level2)
   );

   function automatic logic [2:0] ref_enc(input logic [3:0] y);
      int hi = 0;
      for (int i = 0; i < 4; i++) if (y[i]) hi = i;
      return {($countones(y) != 1), 2'(hi)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic exp_rdy;
      exp_rdy = !en_n && (mq.size() < 4);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("level", 32'(level), 32'(mq.size()));
      check("err_cnt", 32'(err_cnt), 32'(cnt8));
      check("err_cnt_w2", 32'(err_cnt2), 32'(cnt2));
      if (mq.size() > 0) begin
         check("out_code", 32'(out_code), 32'(mq[0][1:0]));
         check("out_err", 32'(out_err), 32'(mq[0][2]));
      end
   endtask

   task automatic model_reset();
      mq.delete();
      cnt8 = 0;
      cnt2 = 0;
   endtask

   task automatic step(input logic v, input logic [3:0] y,
                       input logic en, input logic rdy);
      logic       push, pop;
      logic [2:0] e;
      in_valid  = v;
      in_y      = y;
      en_n      = en;
      out_ready = rdy;
      #1;
      check_all();
      push = v && !en && (mq.size() < 4);
      pop  = (mq.size() > 0) && rdy;
      e    = ref_enc(y);
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push) begin
         mq.push_back(e);
         if (e[2]) begin
            if (cnt8 < 255) cnt8++;
            if (cnt2 < 3) cnt2++;
         end
      end
      #1;
   endtask

   task automatic check_reset_vals();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_err_cnt_w2", 32'(err_cnt2), 32'd0);
      check("rst_out_code", 32'(out_code), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
   endtask

   initial begin
      logic [3:0] w;
      rst_n     = 1'b0;
      en_n      = 1'b0;
      in_valid  = 1'b1;
      in_y      = 4'b0001;
      out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      rst_n = 1'b1;

      // one-hot sweep
      step(1, 4'b0001, 0, 1);
      step(1, 4'b0010, 0, 1);
      step(1, 4'b0100, 0, 1);
      step(1, 4'b1000, 0, 1);
      step(0, 4'b0000, 0, 1);

      // fill, 5th word refused, then drain in order
      step(1, 4'b0001, 0, 0);
      step(1, 4'b0010, 0, 0);
      step(1, 4'b0100, 0, 0);
      step(1, 4'b1000, 0, 0);
      step(1, 4'b0001, 0, 0);
      check("full_level", 32'(level), 32'd4);
      repeat (5) step(0, 4'b0000, 0, 1);

      // error words and 2-bit saturation
      step(1, 4'b0000, 0, 0);
      step(1, 4'b0110, 0, 0);
      step(1, 4'b1111, 0, 0);
      check("err3", 32'(err_cnt), 32'd3);
      step(0, 4'b0000, 0, 1);
      step(1, 4'b0011, 0, 1);
      check("err_sat_w2", 32'(err_cnt2), 32'd3);
      check("err4", 32'(err_cnt), 32'd4);
      repeat (4) step(0, 4'b0000, 0, 1);

      // enable gating drains, presented error words not counted
      step(1, 4'b0100, 0, 0);
      step(1, 4'b1000, 0, 0);
      repeat (4) step(1, 4'b0000, 1, 1);
      check("gate_level", 32'(level), 32'd0);
      check("gate_err", 32'(err_cnt), 32'd4);

      // steady push/pop at level 2 across pointer wrap
      step(1, 4'b0001, 0, 0);
      step(1, 4'b0010, 0, 0);
      for (int i = 0; i < 10; i++) begin
         w = 4'b0001 << (i % 4);
         step(1, w, 0, 1);
      end
      check("wrap_level", 32'(level), 32'd2);
      repeat (3) step(0, 4'b0000, 0, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                         : 4'b0001 << $urandom_range(0, 3);
         step(1'($urandom), w, ($urandom_range(0, 4) == 0),
              1'($urandom));
      end

      // async reset mid-stream at level 3
      for (int i = 0; i < 6 && mq.size() > 0; i++)
         step(0, 4'b0000, 0, 1);
      step(1, 4'b0110, 0, 0);
      step(1, 4'b0001, 0, 0);
      step(1, 4'b0000, 0, 0);
      check("pre_rst_level", 32'(level), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      model_reset();
      #2;
      rst_n = 1'b1;
      step(0, 4'b0000, 0, 1);
      step(1, 4'b1000, 0, 1);
      step(0, 4'b0000, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
